piso_feeder: RTL and testbench

Parallel-in/serial-out feeder that sits directly upstream of the team's SIPO register. It accepts parallel words over a valid/ready handshake and serialises each word MSB-first or LSB-first on serial_out. It drives shift_en as the SIPO's shift/load strobe, with a guaranteed idle gap between words so the SIPO's parallel output becomes visible. A one-entry pending buffer allows back-to-back words without dropping throughput below W+GAP cycles per word.

---
 rtl/piso_feeder.sv | 142 ++++++++++++++
 tb/tb_piso_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_feeder.sv
// Parallel-in/serial-out feeder for the SIPO register: takes words over valid/ready,
// shifts each one out MSB- or LSB-first under shift_en, then idles GAP_CYCLES cycles.
module piso_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_msb_first,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  serial_out,
  output logic                  shift_en,
  output logic                  word_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  order, order_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic [GW-1:0]         gap_cnt, gap_cnt_d;
  logic [DATA_WIDTH-1:0] pend_data, pend_data_d;
  logic                  pend_msb, pend_msb_d;
  logic                  pend_valid, pend_valid_d;
  logic [CNT_WIDTH-1:0]  words_sent_d;
  logic                  serial_out_d, shift_en_d, word_done_d, busy_d;

  logic accept, last_bit, gap_end, load_pend, load_new, load, to_pend;

  // Handshake: a word transfers on the rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and in_data/in_msb_first are captured on that edge.
  assign in_ready  = arst_n && !pend_valid && !flush;
  assign accept    = in_valid && in_ready;
  assign last_bit  = (state == SHIFT) && (bit_cnt == BIT_LAST);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
  assign load_pend = gap_end && pend_valid && !flush;
  assign load_new  = accept && ((state == IDLE) || gap_end);
  assign load      = load_pend || load_new;
  assign to_pend   = accept && !load_new;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = GAP;
      GAP:     if (gap_end) state_d = load ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    shreg_d      = shreg;
    order_d      = order;
    bit_cnt_d    = bit_cnt;
    gap_cnt_d    = gap_cnt;
    pend_data_d  = pend_data;
    pend_msb_d   = pend_msb;
    pend_valid_d = pend_valid;
    words_sent_d = words_sent;

    if (load) begin
      shreg_d   = load_pend ? pend_data : in_data;
      order_d   = load_pend ? pend_msb : in_msb_first;
      bit_cnt_d = '0;
    end else if (state == SHIFT) begin
      shreg_d   = order ? (shreg << 1) : (shreg >> 1);
      bit_cnt_d = last_bit ? '0 : bit_cnt + 1'b1;
    end

    // gap_cnt is held at zero while shifting so the GAP phase always starts from zero
    if (state == SHIFT)    gap_cnt_d = '0;
    else if (state == GAP) gap_cnt_d = gap_cnt + 1'b1;

    if (last_bit && !flush) words_sent_d = words_sent + 1'b1;

    if (to_pend) begin
      pend_valid_d = 1'b1;
      pend_data_d  = in_data;
      pend_msb_d   = in_msb_first;
    end
    if (load_pend) pend_valid_d = 1'b0;

    if (flush) begin
      pend_valid_d = 1'b0;
      bit_cnt_d    = '0;
    end

    shift_en_d   = (state_d == SHIFT);
    serial_out_d = (state_d == SHIFT) && (order_d ? shreg_d[DATA_WIDTH-1] : shreg_d[0]);
    word_done_d  = last_bit && !flush;
    busy_d       = (state_d != IDLE) || pend_valid_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shreg      <= '0;
      order      <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      pend_data  <= '0;
      pend_msb   <= 1'b0;
      pend_valid <= 1'b0;
      words_sent <= '0;
      serial_out <= 1'b0;
      shift_en   <= 1'b0;
      word_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      shreg      <= shreg_d;
      order      <= order_d;
      bit_cnt    <= bit_cnt_d;
      gap_cnt    <= gap_cnt_d;
      pend_data  <= pend_data_d;
      pend_msb   <= pend_msb_d;
      pend_valid <= pend_valid_d;
      words_sent <= words_sent_d;
      serial_out <= serial_out_d;
      shift_en   <= shift_en_d;
      word_done  <= word_done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_piso_feeder.sv
// Bench for piso_feeder with W=8, GAP=1 and a 2-bit word counter so wrap is exercised.
module tb_piso_feeder;

  localparam int W  = 8;
  localparam int G  = 1;
  localparam int CW = 2;
  localparam int NRAND = 2000;
  localparam int NARR  = 2200;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_msb_first = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          serial_out, shift_en, word_done, busy;
  logic [CW-1:0] words_sent;

  always #5 clk = ~clk;

  piso_feeder #(.DATA_WIDTH(W), .GAP_CYCLES(G), .CNT_WIDTH(CW)) dut (
    .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_msb_first(in_msb_first),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .serial_out(serial_out),
    .shift_en(shift_en), .word_done(word_done), .busy(busy), .words_sent(words_sent)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]  data;
    logic          msb;
    logic [W-1:0]  bits;  // transmission order, first bit in the MSB position
    logic [CW-1:0] ws;
  } vec_t;

  vec_t vecs[6];
  int   ws_exp;

  // Monitor for the back-to-back sequence
  bit   mon_on = 1'b0;
  logic se_q[$];
  logic so_q[$];
  always @(negedge clk) if (mon_on) begin
    se_q.push_back(shift_en);
    so_q.push_back(serial_out);
  end

  // Sends one word from idle and checks the whole serial frame; starts and ends just after a posedge.
  task automatic run_vec(input vec_t v, input string tag);
    in_data = v.data; in_msb_first = v.msb; in_valid = 1'b1;
    check({tag, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check({tag, "_shift_en"}, shift_en, 1);
      check({tag, "_bit"}, serial_out, v.bits[W-1-i]);
      if (i == 0) check({tag, "_busy"}, busy, 1);
    end
    @(negedge clk);
    check({tag, "_done"}, word_done, 1);
    check({tag, "_gap_se"}, shift_en, 0);
    check({tag, "_gap_so"}, serial_out, 0);
    check({tag, "_ws"}, words_sent, v.ws);
    @(negedge clk);
    check({tag, "_done_low"}, word_done, 0);
    check({tag, "_idle"}, busy, 0);
    @(posedge clk); #1;
  endtask

  bit saw_block;
  task automatic push(input logic [W-1:0] d, input logic m);
    int n;
    in_data = d; in_msb_first = m; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      saw_block = 1'b1;
      n++;
      if (n > 100) begin
        check("push_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Reference model state for random traffic: per-cycle expected outputs
  bit e_se[NARR];
  bit e_so[NARR];
  bit e_wd[NARR];

  initial begin
    logic [23:0] stream;
    int f, quiet, free_at, last_start, ws_m, a, s;
    bit exp_ready;

    #1 watchdog_dummy();
    // Reset state
    #11;
    check("rst_serial_out", serial_out, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_word_done", word_done, 0);
    check("rst_busy", busy, 0);
    check("rst_words_sent", words_sent, 0);
    check("rst_in_ready", in_ready, 0);
    #11 arst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // Table of single words from idle; words_sent wraps modulo 4
    vecs[0] = '{8'hA5, 1'b1, 8'b1010_0101, 2'd1};
    vecs[1] = '{8'hA5, 1'b0, 8'b1010_0101, 2'd2};
    vecs[2] = '{8'h01, 1'b0, 8'b1000_0000, 2'd3};
    vecs[3] = '{8'h01, 1'b1, 8'b0000_0001, 2'd0};
    vecs[4] = '{8'h0F, 1'b0, 8'b1111_0000, 2'd1};
    vecs[5] = '{8'h0F, 1'b1, 8'b0000_1111, 2'd2};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    ws_exp = 2;

    // Back-to-back with in_valid held throughout
    saw_block = 1'b0;
    mon_on = 1'b1;
    push(8'h3C, 1'b1);
    push(8'hC3, 1'b1);
    push(8'hFF, 1'b1);
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 mon_on = 1'b0;
    ws_exp = (ws_exp + 3) % 4;
    check("b2b_ready_dropped", saw_block, 1);
    check("b2b_ws", words_sent, ws_exp);
    stream = 24'h3CC3FF;
    f = 0;
    while (f < se_q.size() && se_q[f] !== 1'b1) f++;
    if (se_q.size() < f + 28) check("b2b_frame_len", se_q.size(), f + 28);
    else begin
      for (int k = 0; k < 27; k++) begin
        check("b2b_shift_en", se_q[f+k], (k % 9) < 8);
        if ((k % 9) < 8) check("b2b_bit", so_q[f+k], stream[23 - ((k / 9) * 8 + (k % 9))]);
      end
      check("b2b_tail_idle", se_q[f+27], 0);
    end
    @(posedge clk); #1;

    // Flush in the 4th shift cycle of 0x96 with 0x11 pending
    in_data = 8'h96; in_msb_first = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h11;
    check("flush_pend_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_pend_full", in_ready, 0);
    check("flush_pre_se", shift_en, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    check("flush_ready_low", in_ready, 0);
    check("flush_cycle_se", shift_en, 1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_se", shift_en, 0);
    check("flush_busy", busy, 0);
    check("flush_ready", in_ready, 1);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (shift_en || word_done || busy) quiet++;
    end
    check("flush_quiet", quiet, 0);
    check("flush_ws", words_sent, ws_exp);
    @(posedge clk); #1;

    // Async reset mid-word
    in_data = 8'hFF; in_msb_first = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_se", shift_en, 1);
    check("mid_so", serial_out, 1);
    arst_n = 1'b0;
    #1;
    check("arst_serial_out", serial_out, 0);
    check("arst_shift_en", shift_en, 0);
    check("arst_busy", busy, 0);
    check("arst_ws", words_sent, 0);
    check("arst_ready", in_ready, 0);
    @(negedge clk); #2 arst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", in_ready, 1);
    check("rel_se", shift_en, 0);
    @(posedge clk); #1;
    run_vec('{8'h5A, 1'b1, 8'b0101_1010, 2'd1}, "after_rst");
    ws_exp = 1;

    // Random traffic against a schedule model: each word claims W shift cycles then G gap cycles
    free_at = 0; last_start = -1; ws_m = ws_exp;
    for (int c = 0; c < NRAND; c++) begin
      in_valid     = ($urandom_range(0, 9) < 6);
      in_data      = W'($urandom);
      in_msb_first = 1'($urandom_range(0, 1));
      flush        = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      ws_m = (ws_m + int'(e_wd[c])) % 4;
      exp_ready = !flush && !(last_start > c);
      check("rnd_shift_en", shift_en, e_se[c]);
      check("rnd_serial_out", serial_out, e_so[c]);
      check("rnd_word_done", word_done, e_wd[c]);
      check("rnd_busy", busy, c < free_at);
      check("rnd_words_sent", words_sent, ws_m);
      check("rnd_in_ready", in_ready, exp_ready);
      if (flush) begin
        for (int k = c + 1; k < NARR; k++) begin
          e_se[k] = 1'b0; e_so[k] = 1'b0; e_wd[k] = 1'b0;
        end
        free_at = c + 1;
        last_start = -1;
      end else if (in_valid && exp_ready) begin
        a = c + 1;
        s = (a > free_at) ? a : free_at;
        for (int k = 0; k < W; k++) begin
          e_se[s+k] = 1'b1;
          e_so[s+k] = in_msb_first ? in_data[W-1-k] : in_data[k];
        end
        e_wd[s+W] = 1'b1;
        free_at = s + W + G;
        last_start = s;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic watchdog_dummy();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
